// File: rtl/dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter
//
// Round-robin front-end that serialises read/write commands from NUM_PORTS
// requesters onto the single DRAM wrapper command port. Outstanding reads are
// tracked in an in-order tag FIFO so every returned read beat is routed back
// to the port that issued it. Everything runs in the DRAM wrapper clock domain.
//
// Optional feature: define DRAM_PORT_ARBITER_PERF_EN to add perf_grants, one
// 32-bit saturating grant counter per port.
//
// Ports:
//   clock, resetn              clock and synchronous active-low reset
//   req_valid/we/addr/wdata/   per-port command request, fields packed with
//     wmask                    port k at [k*W +: W]
//   req_ready                  one-hot acceptance pulse (combinational)
//   rsp_valid, rsp_rdata       one-hot read-return pulse and shared read data
//   dram_ren/wen/addr/wdata/   command to the DRAM wrapper
//     wmask
//   dram_busy, dram_init_calib_complete, dram_rdata, dram_rdata_valid
//                              status and read return from the wrapper
//   err_orphan                 sticky: read data came back with no tag queued
//   dbg_state                  current FSM state (0 IDLE, 1 ISSUE, 2 SETTLE)
//   perf_grants                per-port grant counters (optional)
//
// Handshake: a requester raises req_valid with stable fields and holds them
// until the cycle req_ready is high for its port; that cycle is the transfer.
// Fields may change from the following cycle on. There is no backpressure on
// rsp_valid: the requester must accept the beat in the pulse cycle.
// -----------------------------------------------------------------------------
module dram_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0]  req_wmask,
  output logic [NUM_PORTS-1:0]             req_ready,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             dram_ren,
  output logic                             dram_wen,
  output logic [ADDR_WIDTH-1:0]            dram_addr,
  output logic [DATA_WIDTH-1:0]            dram_wdata,
  output logic [MASK_WIDTH-1:0]            dram_wmask,
  input  logic                             dram_busy,
  input  logic                             dram_init_calib_complete,
  input  logic [DATA_WIDTH-1:0]            dram_rdata,
  input  logic                             dram_rdata_valid,
  output logic                             err_orphan,
  output logic [1:0]                       dbg_state
`ifdef DRAM_PORT_ARBITER_PERF_EN
  ,
  output logic [NUM_PORTS*32-1:0]          perf_grants
`endif
);

  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam int CNT_W  = TAG_AW + 1;
  localparam logic [CNT_W-1:0] TAG_FULL  = CNT_W'(TAG_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        win_q, win_d;
  logic                    dram_ren_q, dram_ren_d;
  logic                    dram_wen_q, dram_wen_d;
  logic [ADDR_WIDTH-1:0]   dram_addr_q, dram_addr_d;
  logic [DATA_WIDTH-1:0]   dram_wdata_q, dram_wdata_d;
  logic [MASK_WIDTH-1:0]   dram_wmask_q, dram_wmask_d;
  logic [PTR_W-1:0]        tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0]        tag_mem_d [TAG_DEPTH];
  logic [TAG_AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [TAG_AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    err_orphan_q, err_orphan_d;
`ifdef DRAM_PORT_ARBITER_PERF_EN
  logic [31:0]             perf_q [NUM_PORTS];
  logic [31:0]             perf_d [NUM_PORTS];
`endif

  logic [NUM_PORTS-1:0]    eligible;
  logic                    tag_full;
  logic                    found;
  logic [PTR_W-1:0]        win;
  int                      arb_idx;
  logic                    grant;
  logic                    push;
  logic                    pop;
  logic [PTR_W-1:0]        head_tag;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    dram_ren_d   = 1'b0;
    dram_wen_d   = 1'b0;
    dram_addr_d  = dram_addr_q;
    dram_wdata_d = dram_wdata_q;
    dram_wmask_d = dram_wmask_q;
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rsp_rdata_d  = rsp_rdata_q;
    err_orphan_d = err_orphan_q;
    found        = 1'b0;
    win          = '0;
    arb_idx      = 0;
    req_ready    = '0;
    rsp_valid_d  = '0;

    // A read can only be accepted if a tag slot is free at arbitration time;
    // a pop in the same cycle does not help, the check uses the current count.
    tag_full = (cnt_q == TAG_FULL);
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = req_valid[i] & ~(~req_we[i] & tag_full);
    end

    // Search starts at the round-robin pointer and wraps around the ports.
    for (int i = 0; i < NUM_PORTS; i++) begin
      arb_idx = int'(ptr_q) + i;
      if (arb_idx >= NUM_PORTS) arb_idx = arb_idx - NUM_PORTS;
      if (!found && eligible[arb_idx]) begin
        found = 1'b1;
        win   = PTR_W'(arb_idx);
      end
    end

    // resetn gates the combinational grant so req_ready is low during reset.
    grant = resetn && (state_q == ST_IDLE) && dram_init_calib_complete &&
            !dram_busy && found;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req_ready[i] = grant && (win == PTR_W'(i));
    end

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d      = ST_ISSUE;
          win_d        = win;
          ptr_d        = (win == LAST_PORT) ? '0 : win + PTR_W'(1);
          dram_ren_d   = ~req_we[win];
          dram_wen_d   = req_we[win];
          dram_addr_d  = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          dram_wdata_d = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          dram_wmask_d = req_wmask[int'(win)*MASK_WIDTH +: MASK_WIDTH];
        end
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      // Dead cycle: gives the wrapper time to raise dram_busy for this command.
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Tag FIFO: the read's owner is queued in the cycle the read is issued.
    push     = (state_q == ST_ISSUE) && dram_ren_q;
    pop      = dram_rdata_valid && (cnt_q != '0);
    head_tag = tag_mem_q[rd_ptr_q];

    if (push) begin
      tag_mem_d[wr_ptr_q] = win_q;
      wr_ptr_d            = wr_ptr_q + TAG_AW'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + TAG_AW'(1);
      rsp_rdata_d = dram_rdata;
      for (int i = 0; i < NUM_PORTS; i++) begin
        rsp_valid_d[i] = (head_tag == PTR_W'(i));
      end
    end
    if (dram_rdata_valid && (cnt_q == '0)) err_orphan_d = 1'b1;

    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

`ifdef DRAM_PORT_ARBITER_PERF_EN
    perf_d = perf_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_ready[i] && (perf_q[i] != 32'hFFFF_FFFF)) perf_d[i] = perf_q[i] + 32'd1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      dram_ren_q   <= 1'b0;
      dram_wen_q   <= 1'b0;
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      dram_wmask_q <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      err_orphan_q <= 1'b0;
`ifdef DRAM_PORT_ARBITER_PERF_EN
      for (int i = 0; i < NUM_PORTS; i++) perf_q[i] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      dram_ren_q   <= dram_ren_d;
      dram_wen_q   <= dram_wen_d;
      dram_addr_q  <= dram_addr_d;
      dram_wdata_q <= dram_wdata_d;
      dram_wmask_q <= dram_wmask_d;
      tag_mem_q    <= tag_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      err_orphan_q <= err_orphan_d;
`ifdef DRAM_PORT_ARBITER_PERF_EN
      perf_q       <= perf_d;
`endif
    end
  end

  assign dram_ren   = dram_ren_q;
  assign dram_wen   = dram_wen_q;
  assign dram_addr  = dram_addr_q;
  assign dram_wdata = dram_wdata_q;
  assign dram_wmask = dram_wmask_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign err_orphan = err_orphan_q;
  assign dbg_state  = state_q;

`ifdef DRAM_PORT_ARBITER_PERF_EN
  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < NUM_PORTS; i++) perf_grants[i*32 +: 32] = perf_q[i];
  end
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_port_arbiter
//
// Bench for dram_port_arbiter (2 ports, default widths). A behavioural model
// predicts, from the arbitration rules, which port must be granted each cycle,
// what the command port must show one cycle after a grant, and which port each
// returned beat belongs to (a queue of issued read owners). One compare process
// checks the DUT against the model on every cycle; directed tests add literal
// expectations taken straight from the test plan.
// -----------------------------------------------------------------------------
module tb_dram_port_arbiter;

  // ---------------- clock / reset / signals ----------------
  logic         clock;
  logic         resetn;
  logic [1:0]   req_valid;
  logic [1:0]   req_we;
  logic [53:0]  req_addr;
  logic [255:0] req_wdata;
  logic [31:0]  req_wmask;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [127:0] rsp_rdata;
  logic         dram_ren;
  logic         dram_wen;
  logic [26:0]  dram_addr;
  logic [127:0] dram_wdata;
  logic [15:0]  dram_wmask;
  logic         dram_busy;
  logic         calib;
  logic [127:0] dram_rdata;
  logic         dram_rdata_valid;
  logic         err_orphan;
  logic [1:0]   dbg_state;
`ifdef DRAM_PORT_ARBITER_PERF_EN
  logic [63:0]  perf_grants;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  dram_port_arbiter dut (
    .clock                    (clock),
    .resetn                   (resetn),
    .req_valid                (req_valid),
    .req_we                   (req_we),
    .req_addr                 (req_addr),
    .req_wdata                (req_wdata),
    .req_wmask                (req_wmask),
    .req_ready                (req_ready),
    .rsp_valid                (rsp_valid),
    .rsp_rdata                (rsp_rdata),
    .dram_ren                 (dram_ren),
    .dram_wen                 (dram_wen),
    .dram_addr                (dram_addr),
    .dram_wdata               (dram_wdata),
    .dram_wmask               (dram_wmask),
    .dram_busy                (dram_busy),
    .dram_init_calib_complete (calib),
    .dram_rdata               (dram_rdata),
    .dram_rdata_valid         (dram_rdata_valid),
    .err_orphan               (err_orphan),
    .dbg_state                (dbg_state)
`ifdef DRAM_PORT_ARBITER_PERF_EN
    ,
    .perf_grants              (perf_grants)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [127:0] act,
                              input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // exp_q holds the owners of issued, not yet returned reads, oldest first.
  logic [1:0]   exp_q[$];
  bit           m_known = 0;
  int           m_ptr;          // next port to favour
  int           m_gap;          // cycles since the last grant (>=3: arbiter free)
  int           m_win;
  int           m_g;
  logic [1:0]   m_eg;
  logic [1:0]   m_nrv;
  logic [1:0]   m_t;
  logic         e_ren, e_wen, e_err;
  logic [26:0]  e_addr;
  logic [127:0] e_wdata, e_rsp_rdata;
  logic [15:0]  e_wmask;
  logic [1:0]   e_rsp_valid;
  int           m_perf[2];

  always @(negedge clock) begin
    if (m_known) begin
      // Which port must win this cycle.
      m_g = -1;
      if (resetn && (m_gap >= 3) && calib && !dram_busy) begin
        for (int i = 0; i < 2; i++) begin
          int p;
          p = (m_ptr + i) % 2;
          if (m_g < 0 && req_valid[p] && !(!req_we[p] && exp_q.size() == 4)) m_g = p;
        end
      end
      m_eg = 2'b00;
      if (m_g >= 0) m_eg[m_g] = 1'b1;

      chk("req_ready",  128'(req_ready),  128'(m_eg));
      chk("dram_ren",   128'(dram_ren),   128'(e_ren));
      chk("dram_wen",   128'(dram_wen),   128'(e_wen));
      chk("dram_addr",  128'(dram_addr),  128'(e_addr));
      chk("dram_wdata", dram_wdata,       e_wdata);
      chk("dram_wmask", 128'(dram_wmask), 128'(e_wmask));
      chk("rsp_valid",  128'(rsp_valid),  128'(e_rsp_valid));
      chk("rsp_rdata",  rsp_rdata,        e_rsp_rdata);
      chk("err_orphan", 128'(err_orphan), 128'(e_err));
`ifdef DRAM_PORT_ARBITER_PERF_EN
      chk("perf0", 128'(perf_grants[31:0]),  128'(m_perf[0]));
      chk("perf1", 128'(perf_grants[63:32]), 128'(m_perf[1]));
`endif
    end

    // Advance the model to the next cycle.
    if (!resetn) begin
      m_known = 1;
      exp_q.delete();
      m_ptr = 0; m_gap = 3; m_win = 0;
      e_ren = 0; e_wen = 0; e_err = 0;
      e_addr = '0; e_wdata = '0; e_wmask = '0;
      e_rsp_valid = '0; e_rsp_rdata = '0;
      m_perf[0] = 0; m_perf[1] = 0;
    end else if (m_known) begin
      m_nrv = 2'b00;
      if (dram_rdata_valid) begin
        if (exp_q.size() > 0) begin
          m_t = exp_q.pop_front();
          m_nrv[m_t] = 1'b1;
          e_rsp_rdata = dram_rdata;
        end else begin
          e_err = 1'b1;
        end
      end
      if (e_ren) exp_q.push_back(2'(m_win));
      e_rsp_valid = m_nrv;
      e_ren = 0; e_wen = 0;
      if (m_g >= 0) begin
        e_ren   = !req_we[m_g];
        e_wen   = req_we[m_g];
        e_addr  = req_addr[m_g*27 +: 27];
        e_wdata = req_wdata[m_g*128 +: 128];
        e_wmask = req_wmask[m_g*16 +: 16];
        m_win   = m_g;
        m_ptr   = (m_g + 1) % 2;
        m_gap   = 1;
        if (m_perf[m_g] != 32'hFFFF_FFFF) m_perf[m_g]++;
      end else if (m_gap < 3) begin
        m_gap++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    dram_busy = 0; calib = 1; dram_rdata = '0; dram_rdata_valid = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    idle_inputs();
    step();
    step();
    resetn = 1;
  endtask

  task automatic set_req(input int p, input bit v, input bit we,
                         input logic [26:0] a, input logic [127:0] d,
                         input logic [15:0] m);
    req_valid[p] = v;
    req_we[p]    = we;
    req_addr[p*27 +: 27]   = a;
    req_wdata[p*128 +: 128] = d;
    req_wmask[p*16 +: 16]  = m;
  endtask

  // Returns at posedge+1 after the grant edge, ok=0 if no grant within 40 cycles.
  task automatic wait_grant(input int p, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (req_ready[p]) begin
        ok = 1;
        break;
      end
    end
    step();
  endtask

  // One-cycle read-data pulse; returns in the cycle the response is visible.
  task automatic beat(input logic [127:0] d);
    dram_rdata_valid = 1;
    dram_rdata = d;
    step();
    dram_rdata_valid = 0;
  endtask

  // ---------------- directed tests ----------------
  int           n;
  bit           ok;
  int           order[$];
  int           gcyc[$];
  logic [3:0]   ordv;
  logic [127:0] dat [4];
  logic [1:0]   exp_rsp [4];

  initial begin
    resetn = 0;
    idle_inputs();

    // Calibration gate
    do_reset();
    calib = 0;
    set_req(0, 1, 0, 27'h0000123, '0, '0);
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (req_ready != 2'b00 || dram_ren) n++;
    end
    chk("calib_quiet", 128'(n), 128'(0));
    step();
    calib = 1;
    @(negedge clock);
    chk("calib_ready", 128'(req_ready), 128'(2'b01));
    step();
    req_valid[0] = 0;
    @(negedge clock);
    chk("calib_ren", 128'(dram_ren), 128'(1));
    chk("calib_addr", 128'(dram_addr), 128'(27'h0000123));
    step();
    beat(128'h1111_2222_3333_4444_5555_6666_7777_8888);
    @(negedge clock);
    chk("calib_rsp", 128'(rsp_valid), 128'(2'b01));
    step();

    // Round robin with both ports reading continuously
    do_reset();
    set_req(0, 1, 0, 27'h0000A00, '0, '0);
    set_req(1, 1, 0, 27'h0000B00, '0, '0);
    order.delete(); gcyc.delete();
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      @(negedge clock);
      if (req_ready[0]) begin order.push_back(0); gcyc.push_back(i); end
      else if (req_ready[1]) begin order.push_back(1); gcyc.push_back(i); end
    end
    step();
    req_valid = 2'b00;
    chk("rr_count", 128'(order.size()), 128'(4));
    ordv = 4'b0000;
    for (int k = 0; k < order.size() && k < 4; k++) ordv[k] = order[k][0];
    chk("rr_order", 128'(ordv), 128'(4'b1010));
    if (gcyc.size() == 4) chk("rr_spacing", 128'(gcyc[3] - gcyc[0]), 128'(9));
    dat[0] = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
    dat[1] = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
    dat[2] = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
    dat[3] = 128'hDDDD_0000_0000_0000_0000_0000_0000_000D;
    exp_rsp[0] = 2'b01; exp_rsp[1] = 2'b10; exp_rsp[2] = 2'b01; exp_rsp[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      beat(dat[k]);
      @(negedge clock);
      chk("rr_rsp_valid", 128'(rsp_valid), 128'(exp_rsp[k]));
      chk("rr_rsp_rdata", rsp_rdata, dat[k]);
      step();
    end

    // Tag FIFO full: reads blocked, writes still pass
    do_reset();
    set_req(0, 1, 0, 27'h0000040, '0, '0);
    n = 0;
    repeat (30) begin
      @(negedge clock);
      if (req_ready[0]) n++;
    end
    chk("full_reads", 128'(n), 128'(4));
    step();
    set_req(1, 1, 1, 27'h0000050, 128'h5555_5555_5555_5555_5555_5555_5555_5555, 16'h00FF);
    wait_grant(1, ok);
    req_valid[1] = 0;
    chk("full_wr_grant", 128'(ok), 128'(1));
    @(negedge clock);
    chk("full_wen", 128'(dram_wen), 128'(1));
    chk("full_wmask", 128'(dram_wmask), 128'(16'h00FF));
    step();
    beat(128'h77);
    wait_grant(0, ok);
    req_valid[0] = 0;
    chk("full_5th_read", 128'(ok), 128'(1));
    step();
    for (int k = 0; k < 4; k++) begin
      beat(128'(k + 16'h0100));
      step();
    end

    // Busy stall
    do_reset();
    dram_busy = 1;
    set_req(1, 1, 1, 27'h00001AB, 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF, 16'h0000);
    n = 0;
    repeat (10) begin
      @(negedge clock);
      if (dram_wen || req_ready != 2'b00) n++;
    end
    chk("busy_quiet", 128'(n), 128'(0));
    step();
    dram_busy = 0;
    @(negedge clock);
    chk("busy_ready", 128'(req_ready), 128'(2'b10));
    step();
    req_valid[1] = 0;
    @(negedge clock);
    chk("busy_wen", 128'(dram_wen), 128'(1));
    chk("busy_wdata", dram_wdata, 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF);
    step();

    // Reset with reads outstanding, then orphan returns
    do_reset();
    set_req(0, 1, 0, 27'h0000300, '0, '0);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(negedge clock);
      if (req_ready[0]) n++;
    end
    step();
    req_valid[0] = 0;
    step();
    step();
    chk("orph_reads", 128'(n), 128'(2));
    resetn = 0;
    step();
    resetn = 1;
    n = 0;
    beat(128'hE1);
    @(negedge clock);
    if (rsp_valid != 2'b00) n++;
    step();
    beat(128'hE2);
    @(negedge clock);
    if (rsp_valid != 2'b00) n++;
    chk("orph_err_set", 128'(err_orphan), 128'(1));
    step();
    chk("orph_no_rsp", 128'(n), 128'(0));
    n = 0;
    repeat (6) begin
      @(negedge clock);
      if (!err_orphan) n++;
    end
    chk("orph_err_held", 128'(n), 128'(0));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
